// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl
//   Converts an unsigned binary value to four BCD digits with a sequential
//   double-dabble engine, then multiplexes the digits onto a common-anode
//   four-digit seven-segment display. Conversion and scanning run side by side.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous, active-high reset
//   in_valid  : in_value is presented for conversion
//   in_ready  : block accepts in_value this cycle (IDLE only)
//   in_value  : unsigned binary value, BITS wide
//   blank_lz  : leading-zero blanking enable, sampled every cycle
//   an        : active-low one-hot anode, an[0] = ones digit
//   seg       : active-low segments {g,f,e,d,c,b,a}
//   dp        : active-low decimal point, always off
//   busy      : conversion in progress (!in_ready)
//   overflow  : last committed value exceeded 9999 (shown as 9999)
module bcd_display_ctrl #(
    parameter int unsigned BITS        = 14,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_value,
    input  logic            blank_lz,
    output logic [3:0]      an,
    output logic [6:0]      seg,
    output logic            dp,
    output logic            busy,
    output logic            overflow
);

    localparam int unsigned CW = $clog2(BITS + 1);
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] bin_q, bin_d;
    logic [15:0]     bcd_q, bcd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_ovf_q, pend_ovf_d;
    logic [15:0]     digits_q, digits_d;
    logic            overflow_q, overflow_d;
    logic [RW-1:0]   refresh_q, refresh_d;
    logic [1:0]      slot_q, slot_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;

    logic [13:0]     ext;
    logic [13:0]     clamped;
    logic [15:0]     adj;
    logic [3:0]      cur_digit;
    logic            blank;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    seg_lut = 7'b1000000;
            4'd1:    seg_lut = 7'b1111001;
            4'd2:    seg_lut = 7'b0100100;
            4'd3:    seg_lut = 7'b0110000;
            4'd4:    seg_lut = 7'b0011001;
            4'd5:    seg_lut = 7'b0010010;
            4'd6:    seg_lut = 7'b0000010;
            4'd7:    seg_lut = 7'b1111000;
            4'd8:    seg_lut = 7'b0000000;
            4'd9:    seg_lut = 7'b0010000;
            default: seg_lut = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        pend_ovf_d = pend_ovf_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;

        // Clamp is evaluated at 14 bits so narrower BITS never needs it.
        ext     = 14'(in_value);
        clamped = (ext > 14'd9999) ? 14'd9999 : ext;

        for (int unsigned i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                      : bcd_q[4*i +: 4];
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d      = clamped[BITS-1:0];
                    pend_ovf_d = (ext > 14'd9999);
                    bcd_d      = '0;
                    cnt_d      = CW'(BITS);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = 16'({adj, bin_q[BITS-1]});
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CW'(1);
                // Counter holds the steps still to run, so 1 marks the last one.
                if (cnt_q == CW'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d   = bcd_q;
                overflow_d = pend_ovf_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Free-running scan, independent of the conversion FSM.
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            slot_d    = slot_q + 2'd1;
        end else begin
            refresh_d = refresh_q + RW'(1);
            slot_d    = slot_q;
        end

        cur_digit = digits_q[{slot_q, 2'b00} +: 4];
        case (slot_q)
            2'd1:    blank = blank_lz && (digits_q[15:4]  == 12'd0);
            2'd2:    blank = blank_lz && (digits_q[15:8]  == 8'd0);
            2'd3:    blank = blank_lz && (digits_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase

        an_d  = ~(4'b0001 << slot_q);
        seg_d = blank ? 7'b1111111 : seg_lut(cur_digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_ovf_q <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            refresh_q  <= '0;
            slot_q     <= '0;
            an_q       <= 4'b1110;
            seg_q      <= 7'b1000000;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            pend_ovf_q <= pend_ovf_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            refresh_q  <= refresh_d;
            slot_q     <= slot_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = 1'b1;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb_bcd_display_ctrl
//   Directed bench for bcd_display_ctrl with BITS=14, REFRESH_DIV=4.
//   Expected segment patterns are hand-written constants.
module tb_bcd_display_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_value;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, SB = 7'b1111111;

    bcd_display_ctrl #(.BITS(14), .REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0: digit_seg = S0;  4'd1: digit_seg = S1;  4'd2: digit_seg = S2;
            4'd3: digit_seg = S3;  4'd4: digit_seg = S4;  4'd5: digit_seg = S5;
            4'd6: digit_seg = S6;  4'd7: digit_seg = S7;  4'd8: digit_seg = S8;
            4'd9: digit_seg = S9;  default: digit_seg = SB;
        endcase
    endfunction

    // Expected seg for slot k given the four expected BCD digits.
    function automatic logic [6:0] exp_seg(input logic [15:0] d, input logic blank, input int k);
        logic [15:0] upper;
        upper = d >> (4 * k);
        if (blank && k > 0 && upper == 16'd0) exp_seg = SB;
        else exp_seg = digit_seg(upper[3:0]);
    endfunction

    task automatic get_seg(input int k, output logic [6:0] s);
        int n;
        logic [3:0] want;
        want = ~(4'b0001 << k);
        n = 0;
        while (an !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("scan_timeout", {28'd0, an}, {28'd0, want});
        s = seg;
    endtask

    task automatic check_slots(input string tag, input logic [15:0] d, input logic blank);
        logic [6:0] s;
        for (int k = 0; k < 4; k++) begin
            get_seg(k, s);
            check($sformatf("%s_slot%0d", tag, k), {25'd0, s}, {25'd0, exp_seg(d, blank, k)});
        end
    endtask

    task automatic wait_ready(input string tag);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, cyc, 15);
        repeat (2) @(negedge clk);
    endtask

    task automatic convert(input string tag, input logic [13:0] v);
        in_valid = 1'b1;
        in_value = v;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ready(tag);
    endtask

    initial begin
        logic [6:0] s;
        int k;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_an",       {28'd0, an},  {28'd0, 4'b1110});
        check("rst_seg",      {25'd0, seg}, {25'd0, S0});
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_busy",     {31'd0, busy}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        check("rst_dp",       {31'd0, dp}, 1);

        // Valid during reset is not taken; taken on the first edge after release.
        in_valid = 1'b1;
        in_value = 14'd5;
        @(negedge clk);
        check("rst_hold_ready", {31'd0, in_ready}, 1);
        rst = 1'b0;
        @(negedge clk);
        check("accept_after_rst", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        wait_ready("v5");
        check_slots("v5", 16'h0005, 1'b0);

        convert("v1234", 14'd1234);
        check("v1234_ovf", {31'd0, overflow}, 0);
        check_slots("v1234", 16'h1234, 1'b0);

        convert("v16383", 14'd16383);
        check("v16383_ovf", {31'd0, overflow}, 1);
        check_slots("v16383", 16'h9999, 1'b0);

        convert("v42", 14'd42);
        check("v42_ovf", {31'd0, overflow}, 0);
        check_slots("v42", 16'h0042, 1'b0);
        blank_lz = 1'b1;
        repeat (2) @(negedge clk);
        check_slots("v42_blank", 16'h0042, 1'b1);

        convert("v7", 14'd7);
        check_slots("v7_blank", 16'h0007, 1'b1);
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        check_slots("v7_noblank", 16'h0007, 1'b0);

        // Hold a second value while busy: it must wait for the next IDLE cycle.
        in_valid = 1'b1;
        in_value = 14'd100;
        @(negedge clk);
        in_value = 14'd555;
        wait_ready("v100");
        check("v555_accepted", {31'd0, in_ready}, 0);
        for (int j = 0; j < 4; j++) begin
            case (an)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                default: k = 3;
            endcase
            check($sformatf("v100_seen%0d", j), {25'd0, seg}, {25'd0, exp_seg(16'h0100, 1'b0, k)});
            repeat (4) @(negedge clk);
        end
        in_valid = 1'b0;
        k = 0;
        while (!in_ready && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("v555_done", {31'd0, in_ready}, 1);
        repeat (2) @(negedge clk);
        check_slots("v555", 16'h0555, 1'b0);

        convert("v9999", 14'd9999);
        check("v9999_ovf", {31'd0, overflow}, 0);
        check_slots("v9999", 16'h9999, 1'b0);

        convert("v0", 14'd0);
        check_slots("v0", 16'h0000, 1'b0);
        blank_lz = 1'b1;
        repeat (2) @(negedge clk);
        check_slots("v0_blank", 16'h0000, 1'b1);
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of converting 8888 throws the conversion away.
        in_valid = 1'b1;
        in_value = 14'd8888;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("v8888_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", {31'd0, in_ready}, 1);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst_ready_after", {31'd0, in_ready}, 1);
        check("midrst_ovf", {31'd0, overflow}, 0);
        check_slots("midrst", 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
